gpio_ctrl_param: RTL and testbench
==================================

Name: gpio_ctrl_param

Overview:
- Parametrised next-generation GPIO controller: WIDTH pins, per-pin direction, output value and aux-function muxing.
- Inputs pass through a SYNC_STAGES synchroniser and a programmable per-pin debouncer, with optional external-clock-qualified sampling.
- Per-pin edge interrupts (rising, falling or both) are latched as sticky, write-1-to-clear status.
- Sits on the simple register bus (gpio_we/gpio_addr/gpio_dat_i/gpio_dat_o) beside the system interrupt controller.

Parameters:
WIDTH, 32, number of GPIO pins (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2), applied to in_pad_i and gpio_eclk
DEB_W, 8, width of DEBOUNCE register and per-pin debounce counters

Ports:
sysclk  in  1  sole clock; all state on rising edge
sysrst  in  1  reset, synchronous, active-high
gpio_we  in  1  write strobe, sampled on sysclk edge
gpio_addr  in  32  byte address; [7:2] decoded, [31:8] must be 0 else no hit
gpio_dat_i  in  32  write data; [WIDTH-1:0] used
aux_i  in  WIDTH  auxiliary-function output values
in_pad_i  in  WIDTH  asynchronous pad inputs
gpio_eclk  in  1  asynchronous external sampling clock (treated as data)
gpio_inta_o  out  1  interrupt request, level
gpio_dat_o  out  32  registered read data
out_pad_o  out  WIDTH  pad output values
oen_padoe_o  out  WIDTH  pad output enable, 1 = drive

Behaviour:
- Reset (sysrst=1 at edge): all registers, sync flops, debounced state, debounce counters, gpio_dat_o, gpio_inta_o, out_pad_o and oen_padoe_o go to 0.
- Register map, WIDTH bits each, reads zero-extended to 32:
  - 0x00 IN: RO, debounced input.
  - 0x04 OUT, 0x08 OE, 0x0C INTE, 0x10 PTRIG (1 = rising, 0 = falling): RW.
  - 0x14 AUX: RW, 1 = pin sourced from aux_i.
  - 0x18 CTRL: RW, bit0 global interrupt enable, bit1 ECLK mode, other bits read 0.
  - 0x1C INTS: RW1C.
  - 0x20 BOTH: RW, 1 = both edges.
  - 0x24 DEBOUNCE: RW, DEB_W bits.
- Writes to IN or to unmapped addresses are ignored; unmapped reads return 0.
- Write: register updates at the edge where gpio_we=1; takes effect the next cycle.
- Read: gpio_dat_o <= mux(gpio_addr) every cycle regardless of gpio_we; 1-cycle latency.
- out_pad_o[i] = AUX[i] ? aux_i[i] : OUT[i]; oen_padoe_o = OE. Purely from flops and aux_i.
- Sync: s = last of SYNC_STAGES flops on in_pad_i. e = synchronised gpio_eclk. eclk_q = 1 on the cycle e rises (e & ~e_prev).
- Qualified cycle q = CTRL[1] ? eclk_q : 1.
- Debounce (per pin, on q cycles only; counters and d hold otherwise):
  - DEBOUNCE=0: d <= s.
  - Else if s==d: cnt <= 0.
  - Else if cnt==DEBOUNCE-1: d <= s, cnt <= 0.
  - Else cnt <= cnt+1.
  - A change therefore needs DEBOUNCE consecutive qualified cycles of a stable differing s. A glitch shorter than that resets cnt and produces no change.
- Edge detect: d_prev <= d every cycle.
  - rise = d & ~d_prev; fall = ~d & d_prev.
  - ev[i] = BOTH[i] ? (rise|fall) : (PTRIG[i] ? rise : fall).
- INTS[i] <= (INTS[i] & ~clr[i]) | (ev[i] & INTE[i]), where clr = write-1 to 0x1C this cycle.
  - Simultaneous set and clear: set wins.
  - Events with INTE[i]=0 are discarded and not latched.
- gpio_inta_o = CTRL[0] & |INTS, driven from flops (no combinational path from pads).
- Latency, DEBOUNCE=0 and ECLK off: INTS bit set at edge SYNC_STAGES+2 counted from the edge that first samples the new pad level (4 with defaults); gpio_inta_o high the same cycle.
- Changing PTRIG, BOTH or DEBOUNCE mid-operation: applies from the next cycle. In-progress counters are kept but compared against the new threshold; cnt >= new threshold behaves as a terminal count.
- Reset mid-debounce or with INTS pending: everything clears, no spurious event after reset. A pad held high through reset produces a rise after reset, but INTE=0 so nothing is latched.

Test Plan:
1. Write OUT=0xA5A5A5A5, OE=0xFFFFFFFF, read 0x04 -> gpio_dat_o=0xA5A5A5A5 one cycle after the address is applied. out_pad_o=0xA5A5A5A5, oen_padoe_o=0xFFFFFFFF.
2. AUX=0x0000000F, aux_i=0x5, OUT=0 -> out_pad_o=0x00000005. Clear AUX -> out_pad_o=0.
3. INTE=PTRIG=0xFF, CTRL=1, in_pad_i 0->0xF0 -> INTS=0xF0 exactly 4 edges later and gpio_inta_o=1. Write 0x1C=0x30 -> INTS=0xC0. Write 0xC0 -> gpio_inta_o=0.
4. DEBOUNCE=3, pin0 pulse of 2 cycles -> IN[0] stays 0, no interrupt. Pulse of 5 cycles -> IN[0]=1 after 3 stable cycles past the synchroniser.
5. BOTH[1]=1, INTE[1]=1: pin1 rise then fall -> INTS[1] set twice. Issue a W1C on the same cycle as the fall event -> INTS[1] remains 1.
6. CTRL[1]=1, in_pad_i=0x1 with gpio_eclk static -> IN stays 0. One gpio_eclk rising edge -> IN[0]=1. Assert sysrst mid-sequence -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/gpio_ctrl_param.sv
// Parametrised GPIO controller with per-pin direction, aux muxing, synchronised and debounced
// inputs, and sticky edge interrupts on the simple register bus.
module gpio_ctrl_param #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 8
) (
    input  logic             sysclk,
    input  logic             sysrst,
    input  logic             gpio_we,
    input  logic [31:0]      gpio_addr,
    input  logic [31:0]      gpio_dat_i,
    input  logic [WIDTH-1:0] aux_i,
    input  logic [WIDTH-1:0] in_pad_i,
    input  logic             gpio_eclk,
    output logic             gpio_inta_o,
    output logic [31:0]      gpio_dat_o,
    output logic [WIDTH-1:0] out_pad_o,
    output logic [WIDTH-1:0] oen_padoe_o
);

    localparam logic [5:0] AddrIn    = 6'h00;
    localparam logic [5:0] AddrOut   = 6'h01;
    localparam logic [5:0] AddrOe    = 6'h02;
    localparam logic [5:0] AddrInte  = 6'h03;
    localparam logic [5:0] AddrPtrig = 6'h04;
    localparam logic [5:0] AddrAux   = 6'h05;
    localparam logic [5:0] AddrCtrl  = 6'h06;
    localparam logic [5:0] AddrInts  = 6'h07;
    localparam logic [5:0] AddrBoth  = 6'h08;
    localparam logic [5:0] AddrDeb   = 6'h09;

    logic [WIDTH-1:0] out_q, oe_q, inte_q, ptrig_q, aux_q, both_q;
    logic [WIDTH-1:0] ints_q, ints_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [DEB_W-1:0] deb_q, deb_m1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] in_sync_q;
    logic [SYNC_STAGES-1:0]            eclk_sync_q;
    logic                              eclk_prev_q;
    logic                              eclk_rise, qual;

    logic [WIDTH-1:0]            s, d_q, d_d, d_prev_q;
    logic [WIDTH-1:0][DEB_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            rise, fall, ev, clr;

    logic             hit, wr_en;
    logic [5:0]       idx;
    logic [WIDTH-1:0] wdat;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign hit   = (gpio_addr[31:8] == 24'h0);
    assign idx   = gpio_addr[7:2];
    assign wr_en = gpio_we & hit;
    assign wdat  = gpio_dat_i[WIDTH-1:0];
    assign unused_bits = ^{gpio_addr[1:0], gpio_dat_i};

    assign out_pad_o   = (aux_q & aux_i) | (~aux_q & out_q);
    assign oen_padoe_o = oe_q;

    assign s         = in_sync_q[SYNC_STAGES-1];
    assign eclk_rise = eclk_sync_q[SYNC_STAGES-1] & ~eclk_prev_q;
    assign qual      = ctrl_q[1] ? eclk_rise : 1'b1;
    assign deb_m1    = deb_q - DEB_W'(1);

    // Counter at or above the threshold counts as terminal so a lowered DEBOUNCE takes effect.
    always_comb begin
        cnt_d = cnt_q;
        d_d   = d_q;
        if (qual) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (deb_q == '0) begin
                    d_d[i]   = s[i];
                    cnt_d[i] = '0;
                end else if (s[i] == d_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= deb_m1) begin
                    d_d[i]   = s[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign rise = d_q & ~d_prev_q;
    assign fall = ~d_q & d_prev_q;
    assign ev   = (both_q & (rise | fall)) |
                  (~both_q & ((ptrig_q & rise) | (~ptrig_q & fall)));
    assign clr  = (wr_en && idx == AddrInts) ? wdat : '0;
    // Set wins over a simultaneous write-1-to-clear.
    assign ints_d = (ints_q & ~clr) | (ev & inte_q);
    assign ctrl_d = (wr_en && idx == AddrCtrl) ? gpio_dat_i[1:0] : ctrl_q;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (idx)
                AddrIn:    rdata = 32'(d_q);
                AddrOut:   rdata = 32'(out_q);
                AddrOe:    rdata = 32'(oe_q);
                AddrInte:  rdata = 32'(inte_q);
                AddrPtrig: rdata = 32'(ptrig_q);
                AddrAux:   rdata = 32'(aux_q);
                AddrCtrl:  rdata = 32'(ctrl_q);
                AddrInts:  rdata = 32'(ints_q);
                AddrBoth:  rdata = 32'(both_q);
                AddrDeb:   rdata = 32'(deb_q);
                default:   rdata = '0;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            out_q       <= '0;
            oe_q        <= '0;
            inte_q      <= '0;
            ptrig_q     <= '0;
            aux_q       <= '0;
            both_q      <= '0;
            deb_q       <= '0;
            ctrl_q      <= '0;
            ints_q      <= '0;
            in_sync_q   <= '0;
            eclk_sync_q <= '0;
            eclk_prev_q <= 1'b0;
            d_q         <= '0;
            d_prev_q    <= '0;
            cnt_q       <= '0;
            gpio_dat_o  <= '0;
            gpio_inta_o <= 1'b0;
        end else begin
            if (wr_en) begin
                case (idx)
                    AddrOut:   out_q   <= wdat;
                    AddrOe:    oe_q    <= wdat;
                    AddrInte:  inte_q  <= wdat;
                    AddrPtrig: ptrig_q <= wdat;
                    AddrAux:   aux_q   <= wdat;
                    AddrBoth:  both_q  <= wdat;
                    AddrDeb:   deb_q   <= gpio_dat_i[DEB_W-1:0];
                    default:   ;
                endcase
            end
            ctrl_q      <= ctrl_d;
            ints_q      <= ints_d;
            gpio_inta_o <= ctrl_d[0] & (|ints_d);
            gpio_dat_o  <= rdata;
            in_sync_q   <= {in_sync_q[SYNC_STAGES-2:0], in_pad_i};
            eclk_sync_q <= {eclk_sync_q[SYNC_STAGES-2:0], gpio_eclk};
            eclk_prev_q <= eclk_sync_q[SYNC_STAGES-1];
            d_q         <= d_d;
            d_prev_q    <= d_q;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl_param.sv
// Directed bench for gpio_ctrl_param: register table plus hand-written interrupt,
// debounce, ECLK and reset sequences.
module tb_gpio_ctrl_param;

    logic        sysclk = 1'b0;
    logic        sysrst;
    logic        gpio_we;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_dat_i;
    logic [31:0] aux_i;
    logic [31:0] in_pad_i;
    logic        gpio_eclk;
    logic        gpio_inta_o;
    logic [31:0] gpio_dat_o;
    logic [31:0] out_pad_o;
    logic [31:0] oen_padoe_o;

    int passed = 0;
    int total  = 0;

    gpio_ctrl_param dut (
        .sysclk      (sysclk),
        .sysrst      (sysrst),
        .gpio_we     (gpio_we),
        .gpio_addr   (gpio_addr),
        .gpio_dat_i  (gpio_dat_i),
        .aux_i       (aux_i),
        .in_pad_i    (in_pad_i),
        .gpio_eclk   (gpio_eclk),
        .gpio_inta_o (gpio_inta_o),
        .gpio_dat_o  (gpio_dat_o),
        .out_pad_o   (out_pad_o),
        .oen_padoe_o (oen_padoe_o)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        bit          do_wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        gpio_we    = 1'b1;
        gpio_addr  = a;
        gpio_dat_i = d;
        tick();
        gpio_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        gpio_addr = a;
        tick();
        d = gpio_dat_o;
    endtask

    task automatic do_reset();
        sysrst = 1'b1;
        tick();
        sysrst = 1'b0;
    endtask

    logic [31:0] r;
    logic        seen;

    initial begin
        sysrst = 1'b1; gpio_we = 1'b0; gpio_addr = '0; gpio_dat_i = '0;
        aux_i = '0; in_pad_i = '0; gpio_eclk = 1'b0;
        tick(2);
        sysrst = 1'b0;
        check("rst_dat", gpio_dat_o, 32'h0);
        check("rst_out", out_pad_o, 32'h0);
        check("rst_oe", oen_padoe_o, 32'h0);
        check("rst_inta", 32'(gpio_inta_o), 32'h0);

        vecs[0]  = '{"out",      32'h04,  1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[1]  = '{"oe",       32'h08,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2]  = '{"inte",     32'h0C,  1'b1, 32'h12345678, 32'h12345678};
        vecs[3]  = '{"ptrig",    32'h10,  1'b1, 32'h0F0F0F0F, 32'h0F0F0F0F};
        vecs[4]  = '{"aux",      32'h14,  1'b1, 32'h00000000, 32'h00000000};
        vecs[5]  = '{"ctrl",     32'h18,  1'b1, 32'hFFFFFFFC, 32'h00000000};
        vecs[6]  = '{"both",     32'h20,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[7]  = '{"debounce", 32'h24,  1'b1, 32'h00001234, 32'h00000034};
        vecs[8]  = '{"in_ro",    32'h00,  1'b1, 32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{"unmapped", 32'h28,  1'b1, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{"hi_addr",  32'h104, 1'b1, 32'h00000001, 32'h00000000};
        vecs[11] = '{"out_keep", 32'h04,  1'b0, 32'h0,        32'hA5A5A5A5};
        vecs[12] = '{"ints_0",   32'h1C,  1'b1, 32'hFFFFFFFF, 32'h00000000};
        vecs[13] = '{"ctrl_rd",  32'h18,  1'b1, 32'h00000003, 32'h00000003};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, r);
            check(vecs[i].name, r, vecs[i].exp);
        end

        // Test 1: pads and read latency
        check("t1_out_pad", out_pad_o, 32'hA5A5A5A5);
        check("t1_oen", oen_padoe_o, 32'hFFFFFFFF);
        gpio_addr = 32'h08;
        tick();
        gpio_addr = 32'h04;
        #2;
        check("t1_rd_not_yet", gpio_dat_o, 32'hFFFFFFFF);
        tick();
        check("t1_rd_lat1", gpio_dat_o, 32'hA5A5A5A5);

        // Test 2: aux muxing
        do_reset();
        wr(32'h14, 32'h0000000F);
        aux_i = 32'h5;
        #1;
        check("t2_aux_out", out_pad_o, 32'h00000005);
        wr(32'h14, 32'h0);
        check("t2_aux_clr", out_pad_o, 32'h0);
        aux_i = '0;

        // Test 3: rising interrupts and W1C
        wr(32'h0C, 32'hFF);
        wr(32'h10, 32'hFF);
        wr(32'h18, 32'h1);
        in_pad_i = 32'hF0;
        tick(3);
        check("t3_inta_early", 32'(gpio_inta_o), 32'h0);
        tick();
        check("t3_inta_4", 32'(gpio_inta_o), 32'h1);
        rd(32'h1C, r);
        check("t3_ints", r, 32'hF0);
        wr(32'h1C, 32'h30);
        rd(32'h1C, r);
        check("t3_ints_w1c", r, 32'hC0);
        check("t3_inta_keep", 32'(gpio_inta_o), 32'h1);
        wr(32'h1C, 32'hC0);
        check("t3_inta_clr", 32'(gpio_inta_o), 32'h0);

        // Test 4: debounce filtering
        in_pad_i = '0;
        do_reset();
        tick(3);
        wr(32'h24, 32'h3);
        wr(32'h0C, 32'h1);
        wr(32'h10, 32'h1);
        wr(32'h18, 32'h1);
        gpio_addr = 32'h00;
        in_pad_i = 32'h1;
        tick(2);
        in_pad_i = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | gpio_dat_o[0] | gpio_inta_o;
        end
        check("t4_glitch", 32'(seen), 32'h0);
        in_pad_i = 32'h1;
        tick(5);
        check("t4_not_yet", gpio_dat_o, 32'h0);
        in_pad_i = 32'h0;
        tick();
        check("t4_in_set", gpio_dat_o, 32'h1);
        check("t4_inta", 32'(gpio_inta_o), 32'h1);

        // Test 5: both-edge interrupts, set beats clear
        do_reset();
        tick(3);
        wr(32'h20, 32'h2);
        wr(32'h0C, 32'h2);
        wr(32'h18, 32'h1);
        in_pad_i = 32'h2;
        tick(4);
        check("t5_rise", 32'(gpio_inta_o), 32'h1);
        wr(32'h1C, 32'h2);
        check("t5_clr", 32'(gpio_inta_o), 32'h0);
        in_pad_i = 32'h0;
        tick(3);
        wr(32'h1C, 32'h2);
        check("t5_set_wins", 32'(gpio_inta_o), 32'h1);
        rd(32'h1C, r);
        check("t5_ints", r, 32'h2);
        wr(32'h1C, 32'h2);
        check("t5_clr2", 32'(gpio_inta_o), 32'h0);

        // Test 6: ECLK-qualified sampling and reset mid-sequence
        do_reset();
        wr(32'h18, 32'h3);
        wr(32'h0C, 32'h1);
        wr(32'h10, 32'h1);
        wr(32'h04, 32'hFF);
        wr(32'h08, 32'hFF);
        in_pad_i  = 32'h1;
        gpio_addr = 32'h00;
        tick(10);
        check("t6_static", gpio_dat_o, 32'h0);
        check("t6_static_int", 32'(gpio_inta_o), 32'h0);
        gpio_eclk = 1'b1;
        tick(6);
        check("t6_eclk_in", gpio_dat_o, 32'h1);
        check("t6_eclk_int", 32'(gpio_inta_o), 32'h1);
        do_reset();
        check("t6_rst_dat", gpio_dat_o, 32'h0);
        check("t6_rst_out", out_pad_o, 32'h0);
        check("t6_rst_oe", oen_padoe_o, 32'h0);
        check("t6_rst_inta", 32'(gpio_inta_o), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | gpio_inta_o;
        end
        check("t6_no_spurious", 32'(seen), 32'h0);
        check("t6_in_after", gpio_dat_o, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
